tdm_demux_1to4: RTL and testbench
=================================

Name: tdm_demux_1to4

Overview:
Receive-side counterpart of the 4:1 selector. Takes a time-division-multiplexed sample stream (one channel per valid slot, slot 0 flagged by frame_start) and distributes the samples onto four parallel channel outputs. It registers a complete frame and presents it with a one-cycle frame_valid strobe. It sits at the far end of a TDM link and feeds per-channel consumers.

Parameters:
WIDTH, 1, bit width of each channel sample.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
din  input  WIDTH  TDM sample for the current slot.
din_valid  input  1  din carries a sample this cycle.
frame_start  input  1  qualified by din_valid; the sample is slot 0 (channel 0).
dout  output  4*WIDTH  frame register; channel k is dout[k*WIDTH +: WIDTH].
frame_valid  output  1  one-cycle pulse when dout has just been updated with a complete frame.
locked  output  1  high while the FSM is in RUN.
slot  output  2  slot index expected for the next accepted sample.
sync_err  output  1  one-cycle pulse when frame_start arrives at a slot other than 0 while in RUN.

Behaviour:
- Reset: one clock is used, and reset is synchronous and active-high. On any clock edge with rst=1, the following are forced regardless of other inputs: dout=0, frame_valid=0, sync_err=0, locked=0, slot=0, shadow registers=0, state=HUNT. Reset mid-frame discards the partial frame.
- Sample acceptance: a sample is accepted only when din_valid=1. frame_start with din_valid=0 is ignored. When din_valid=0, all state holds, and frame_valid and sync_err are 0.
- FSM has two states:
  - HUNT: accepted samples without frame_start are dropped. An accepted sample with frame_start is stored in shadow[0]; then slot<=1 and state<=RUN.
  - RUN, accepted sample without frame_start: stored in shadow[slot], and slot increments modulo 4 (3 wraps to 0).
  - RUN, accepted sample with frame_start and slot=0: treated as normal slot 0.
  - RUN, accepted sample with frame_start and slot!=0: resync. sync_err pulses on the next cycle, the partial frame is discarded (no frame_valid), the sample is stored as slot 0, and slot<=1. State stays RUN.
  - RUN, accepted sample at slot 0 without frame_start (flywheel): accepted as slot 0; no error.
- Frame completion: when a slot-3 sample is accepted in RUN, dout is loaded on that clock edge with {din, shadow[2], shadow[1], shadow[0]} (channel 3 taken directly from din). frame_valid is 1 for exactly the following cycle.
- Latency is 1 clock from the slot-3 sample to frame_valid/dout update.
- Back-to-back frames (din_valid continuously high) produce frame_valid every 4th cycle.
- dout holds its value between frames and is never partially updated.
- locked=1 exactly when state=RUN.
- slot is a registered copy of the counter; it reads 0 in HUNT.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Basic frame (WIDTH=4): after reset, din_valid=1 with din=1,2,3,4 on consecutive cycles, frame_start on the first -> the cycle after din=4: dout=16'h4321, frame_valid=1 for one cycle, locked=1, slot=0.
- Hunting: samples 9,9 without frame_start, then frame_start with A,B,C,D -> no frame_valid before sync; then dout=16'hDCBA. locked stays 0 until the cycle after the A sample.
- Gaps: the frame 5,6,7,8 with din_valid=0 for 2 cycles between each sample -> dout=16'h8765, a single frame_valid pulse, and slot advances only on valid cycles.
- Resync: frame_start with 1,2, then frame_start with E,F,0,1 -> sync_err pulses once after E, no frame_valid for the 1,2 fragment, and then dout=16'h10FE.
- Continuous stream: 3 frames back-to-back with frame_start only on the first -> frame_valid pulses exactly 4 cycles apart, dout matches each frame, and sync_err=0.
- Reset mid-frame: frame_start with 1,2, then rst=1 for 1 cycle, then 3,4 without frame_start -> all outputs 0, locked=0, and no frame_valid.

Source files
------------

// File: rtl/tdm_demux_1to4_if.sv
// rtl/tdm_demux_1to4_if.sv - TDM sample input and frame output bundle for tdm_demux_1to4
interface tdm_demux_1to4_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0]   din;
   logic               din_valid;
   logic               frame_start;
   logic [4*WIDTH-1:0] dout;
   logic               frame_valid;
   logic               locked;
   logic [1:0]         slot;
   logic               sync_err;

   modport master (
      output din,
      output din_valid,
      output frame_start,
      input  dout,
      input  frame_valid,
      input  locked,
      input  slot,
      input  sync_err
   );

   modport slave (
      input  din,
      input  din_valid,
      input  frame_start,
      output dout,
      output frame_valid,
      output locked,
      output slot,
      output sync_err
   );
endinterface

// File: rtl/tdm_demux_1to4.sv
// rtl/tdm_demux_1to4.sv - 1:4 TDM demultiplexer with frame lock and whole-frame output register
module tdm_demux_1to4 #(
   parameter int WIDTH = 1
) (
   input logic              clk,
   input logic              rst,
   tdm_demux_1to4_if.slave  bus
);
   typedef enum logic {HUNT, RUN} state_t;

   state_t           state;
   logic [1:0]       slot_q;
   logic [WIDTH-1:0] shadow0;
   logic [WIDTH-1:0] shadow1;
   logic [WIDTH-1:0] shadow2;
   logic [4*WIDTH-1:0] dout_q;
   logic             frame_valid_q;
   logic             locked_q;
   logic             sync_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= HUNT;
         slot_q        <= 2'd0;
         shadow0       <= '0;
         shadow1       <= '0;
         shadow2       <= '0;
         dout_q        <= '0;
         frame_valid_q <= 1'b0;
         locked_q      <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
         if (bus.din_valid) begin
            case (state)
               HUNT: begin
                  if (bus.frame_start) begin
                     shadow0  <= bus.din;
                     slot_q   <= 2'd1;
                     state    <= RUN;
                     locked_q <= 1'b1;
                  end
               end
               RUN: begin
                  // A misplaced frame_start restarts the frame; older shadow data is simply overwritten later.
                  if (bus.frame_start && (slot_q != 2'd0)) begin
                     sync_err_q <= 1'b1;
                     shadow0    <= bus.din;
                     slot_q     <= 2'd1;
                  end else begin
                     case (slot_q)
                        2'd0: shadow0 <= bus.din;
                        2'd1: shadow1 <= bus.din;
                        2'd2: shadow2 <= bus.din;
                        default: begin
                           dout_q        <= {bus.din, shadow2, shadow1, shadow0};
                           frame_valid_q <= 1'b1;
                        end
                     endcase
                     slot_q <= slot_q + 2'd1;
                  end
               end
               default: begin
                  state    <= HUNT;
                  slot_q   <= 2'd0;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.dout        = dout_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.locked      = locked_q;
   assign bus.slot        = slot_q;
   assign bus.sync_err    = sync_err_q;
endmodule

// File: tb/tb_tdm_demux_1to4.sv
// tb/tb_tdm_demux_1to4.sv - self-checking bench for tdm_demux_1to4 against a frame-level model
module tb_tdm_demux_1to4;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   tdm_demux_1to4_if #(.WIDTH(W)) bus ();

   tdm_demux_1to4 #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Model: "locked" plus the list of samples collected so far in the current frame.
   bit          m_locked;
   logic [W-1:0] m_frame[$];
   logic [15:0] m_dout;
   bit          m_fv;
   bit          m_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model(input logic [W-1:0] d, input bit dv, input bit fs, input bit r);
      if (r) begin
         m_locked = 0;
         m_frame.delete();
         m_dout = '0;
         m_fv = 0;
         m_err = 0;
      end else begin
         m_fv = 0;
         m_err = 0;
         if (dv) begin
            if (!m_locked) begin
               if (fs) begin
                  m_locked = 1;
                  m_frame = {d};
               end
            end else if (fs && m_frame.size() != 0) begin
               m_err = 1;
               m_frame = {d};
            end else begin
               m_frame.push_back(d);
               if (m_frame.size() == 4) begin
                  m_dout = {m_frame[3], m_frame[2], m_frame[1], m_frame[0]};
                  m_fv = 1;
                  m_frame.delete();
               end
            end
         end
      end
   endtask

   task automatic step(input logic [W-1:0] d, input bit dv, input bit fs, input bit r);
      @(negedge clk);
      rst = r;
      bus.din = d;
      bus.din_valid = dv;
      bus.frame_start = fs;
      @(posedge clk);
      model(d, dv, fs, r);
      #1;
      check("dout", 32'(bus.dout), 32'(m_dout));
      check("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
      check("locked", 32'(bus.locked), 32'(m_locked));
      check("slot", 32'(bus.slot), 32'(m_locked ? m_frame.size() : 0));
      check("sync_err", 32'(bus.sync_err), 32'(m_err));
   endtask

   task automatic send(input logic [W-1:0] d, input bit fs);
      step(d, 1, fs, 0);
   endtask

   task automatic idle();
      step('0, 0, 0, 0);
   endtask

   initial begin
      int last_fv;
      int cyc;
      rst = 1'b1;
      bus.din = '0;
      bus.din_valid = 1'b0;
      bus.frame_start = 1'b0;

      step(4'hF, 1, 1, 1);
      step(4'h0, 0, 0, 1);
      check("reset_locked", 32'(bus.locked), 32'd0);

      // Basic frame
      send(4'h1, 1); send(4'h2, 0); send(4'h3, 0); send(4'h4, 0);
      check("basic_dout", 32'(bus.dout), 32'h4321);
      check("basic_fv", 32'(bus.frame_valid), 32'd1);
      idle();
      check("basic_fv_once", 32'(bus.frame_valid), 32'd0);

      // Hunting
      step(0, 0, 0, 1);
      send(4'h9, 0); send(4'h9, 0);
      check("hunt_locked", 32'(bus.locked), 32'd0);
      send(4'hA, 1);
      check("hunt_lock_after_a", 32'(bus.locked), 32'd1);
      send(4'hB, 0); send(4'hC, 0); send(4'hD, 0);
      check("hunt_dout", 32'(bus.dout), 32'hDCBA);

      // Gaps between samples
      send(4'h5, 1); idle(); idle();
      send(4'h6, 0); idle(); idle();
      send(4'h7, 0); idle(); idle();
      check("gap_slot", 32'(bus.slot), 32'd3);
      send(4'h8, 0);
      check("gap_dout", 32'(bus.dout), 32'h8765);
      idle(); idle();

      // Resync
      send(4'h1, 1); send(4'h2, 0);
      send(4'hE, 1);
      check("resync_err", 32'(bus.sync_err), 32'd1);
      send(4'hF, 0);
      check("resync_err_once", 32'(bus.sync_err), 32'd0);
      send(4'h0, 0); send(4'h1, 0);
      check("resync_dout", 32'(bus.dout), 32'h10FE);

      // Continuous stream: frame_valid every 4th cycle
      last_fv = -1;
      for (int i = 0; i < 12; i++) begin
         send(4'($urandom), i == 0);
         if (bus.frame_valid) begin
            if (last_fv >= 0) check("stream_spacing", 32'(i - last_fv), 32'd4);
            last_fv = i;
         end
      end
      check("stream_last_fv", 32'(last_fv), 32'd11);

      // Reset mid-frame
      send(4'h1, 1); send(4'h2, 0);
      step(0, 0, 0, 1);
      send(4'h3, 0); send(4'h4, 0);
      check("midrst_dout", 32'(bus.dout), 32'h0);
      check("midrst_locked", 32'(bus.locked), 32'd0);

      // Randomized traffic
      for (cyc = 0; cyc < 3000; cyc++) begin
         step(4'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 5) == 0,
              $urandom_range(0, 299) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
